code_conv_sched: RTL and testbench

//  Round-robin scheduler that shares one 3-bit -> 2-bit code converter between NREQ requesters.

---
 rtl/code_conv_sched.sv | 121 ++++++++++++
 tb/tb_code_conv_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/code_conv_sched.sv
// rtl/code_conv_sched.sv - round-robin shared 3->2 bit code converter with valid/ready result port
// Optional macro CONV_STATS_EN adds the completed-conversion counter behind conv_count.
module code_conv_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] code,
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        y_out,
  output logic [IDW-1:0]    y_id,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  conv_count
);

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t         state, state_d;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_r;
  logic [2:0]     code_r;
  logic [IDW-1:0] win;
  logic           found;
  logic [2:0]     code_sel;
  logic [7:0]     onehot;
  logic [1:0]     conv;
  logic           done;

  // Scan starts just past the last served requester, so it ends up lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign code_sel = code[3*int'(win) +: 3];

  // Decode to one-hot, then encode each bit of y as the OR of its groups.
  assign onehot  = 8'b1 << code_r;
  assign conv[0] = onehot[0] | onehot[2] | onehot[3] | onehot[4] | onehot[7];
  assign conv[1] = onehot[0] | onehot[2] | onehot[5] | onehot[6];

  assign done = (state == HOLD) && y_ready;
  assign busy = (state != IDLE);

  always_comb begin
    state_d = state;
    gnt     = '0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          gnt[win] = 1'b1;
          state_d  = CONV;
        end
      end
      CONV:    state_d = HOLD;
      HOLD:    if (y_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= IDW'(NREQ - 1);
      id_r    <= '0;
      code_r  <= '0;
      y_out   <= '0;
      y_id    <= '0;
      y_valid <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (found) begin
            code_r <= code_sel;
            id_r   <= win;
          end
        end
        CONV: begin
          y_out   <= conv;
          y_id    <= id_r;
          y_valid <= 1'b1;
        end
        HOLD: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            ptr     <= id_r;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_STATS_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (done) cnt <= cnt + 1'b1;
  end

  assign conv_count = cnt;
`else
  assign conv_count = '0;
`endif

endmodule

// File: tb/tb_code_conv_sched.sv
// tb/tb_code_conv_sched.sv - directed table-driven bench for code_conv_sched
// Counter checks follow CONV_STATS_EN when it is defined for the build.
module tb_code_conv_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] code;
  logic [3:0]  gnt;
  logic [1:0]  y_out;
  logic [1:0]  y_id;
  logic        y_valid;
  logic        y_ready;
  logic        busy;
  logic [15:0] conv_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [2:0] c;
    logic [1:0] y;
  } vec_t;

  vec_t tab[8];
  int   order[6];

  code_conv_sched #(.NREQ(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .code(code), .gnt(gnt),
    .y_out(y_out), .y_id(y_id), .y_valid(y_valid), .y_ready(y_ready),
    .busy(busy), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string nm);
`ifdef CONV_STATS_EN
    check(nm, conv_count, exp_cnt);
`else
    check(nm, conv_count, 0);
`endif
  endtask

  task automatic wait_gnt(input string nm);
    int n;
    n = 0;
    #1;
    while (gnt == 4'b0 && n < 10) begin
      step();
      #1;
      n++;
    end
    if (gnt == 4'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no grant within %0d cycles", nm, n);
    end
  endtask

  // One full conversion with y_ready high: grant, latency, result, release.
  task automatic serve(input string nm, input logic [3:0] r, input logic [11:0] c,
                       input int exp_id, input logic [1:0] exp_y);
    req  = r;
    code = c;
    wait_gnt(nm);
    check({nm, "_gnt"}, gnt, 32'(1) << exp_id);
    step();
    req = 4'b0;
    check({nm, "_vld_t1"}, y_valid, 0);
    check({nm, "_busy"}, busy, 1);
    step();
    check({nm, "_vld_t2"}, y_valid, 1);
    check({nm, "_y"}, y_out, exp_y);
    check({nm, "_id"}, y_id, exp_id);
    step();
    exp_cnt++;
    check({nm, "_vld_drop"}, y_valid, 0);
    check_cnt({nm, "_cnt"});
  endtask

  initial begin
    tab[0] = '{3'd0, 2'd3}; tab[1] = '{3'd1, 2'd0};
    tab[2] = '{3'd2, 2'd3}; tab[3] = '{3'd3, 2'd1};
    tab[4] = '{3'd4, 2'd1}; tab[5] = '{3'd5, 2'd2};
    tab[6] = '{3'd6, 2'd2}; tab[7] = '{3'd7, 2'd1};
    order  = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1; req = 4'b0; code = 12'b0; y_ready = 1'b1;
    repeat (2) step();
    check("rst_gnt", gnt, 0);
    check("rst_y", y_out, 0);
    check("rst_id", y_id, 0);
    check("rst_vld", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", conv_count, 0);
    rst = 1'b0;

    serve("first", 4'b0001, 12'd5, 0, 2'b10);

    for (int i = 0; i < 8; i++)
      serve($sformatf("sweep%0d", i), 4'b0001, {9'b0, tab[i].c}, 0, tab[i].y);

    // Fairness after reset: strict rotation starting at requester 0, 3 cycles per grant.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    req  = 4'b1111;
    code = {3'd7, 3'd6, 3'd5, 3'd4};
    #1;
    for (int t = 0; t < 16; t++) begin
      if (t % 3 == 0)
        check($sformatf("rr_gnt_t%0d", t), gnt, 32'(1) << order[t/3]);
      else
        check($sformatf("rr_idle_t%0d", t), gnt, 0);
      if (t < 15) step();
    end
    step();
    req = 4'b0;
    step();
    step();
    exp_cnt += 6;
    check("rr_done_busy", busy, 0);
    check_cnt("rr_cnt");

    // Backpressure with other requests pending.
    y_ready = 1'b0;
    req  = 4'b0001;
    code = 12'd4;
    wait_gnt("bp");
    check("bp_gnt", gnt, 1);
    step();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      code = 12'hfff;
      check($sformatf("bp_vld%0d", k), y_valid, 1);
      check($sformatf("bp_y%0d", k), y_out, 2'b01);
      check($sformatf("bp_id%0d", k), y_id, 0);
      check($sformatf("bp_nognt%0d", k), gnt, 0);
      step();
    end
    y_ready = 1'b1;
    step();
    exp_cnt++;
    check("bp_release", y_valid, 0);
    #1;
    check("bp_next_gnt", gnt, 4'b0010);
    step();
    req = 4'b0;
    step();
    check("bp_next_y", y_out, 2'b01);
    check("bp_next_id", y_id, 1);
    step();
    exp_cnt++;
    check_cnt("bp_cnt");

    // Code changes after the grant must not reach y_out.
    req  = 4'b0001;
    code = 12'd3;
    wait_gnt("late");
    check("late_gnt", gnt, 1);
    step();
    req  = 4'b0;
    code = 12'd6;
    step();
    check("late_y", y_out, 2'b01);
    step();
    exp_cnt++;
    check_cnt("late_cnt");

    // Reset while holding a result.
    y_ready = 1'b0;
    req  = 4'b0100;
    code = {3'd0, 3'd5, 6'd0};
    wait_gnt("rh");
    check("rh_gnt", gnt, 4'b0100);
    step();
    req = 4'b0;
    step();
    check("rh_vld", y_valid, 1);
    check("rh_y", y_out, 2'b10);
    rst = 1'b1;
    step();
    exp_cnt = 0;
    check("rh_vld_rst", y_valid, 0);
    check("rh_busy_rst", busy, 0);
    check_cnt("rh_cnt_rst");
    rst = 1'b0;
    y_ready = 1'b1;
    serve("rh_after", 4'b1111, {3'd1, 3'd1, 3'd1, 3'd2}, 0, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
